// File: rtl/mem_burst_reader_pkg.sv
// Shared definitions for the burst reader: FSM state encodings and the
// depth of the output FIFO that absorbs the memory's read latency.
package mem_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry synchronous FIFO holding words returned by the memory until
// the downstream consumer accepts them.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push, din       write one entry (ignored when full unless popping too)
//   pop             remove the head entry (ignored when empty)
//   dout            head entry, straight from the storage registers
//   count, empty    occupancy 0..2 and empty flag
module stream_fifo2
  import mem_burst_reader_pkg::*;
#(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       count,
  output logic             empty
);

  logic [WIDTH-1:0] store [FIFO_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 2'd0);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign do_push = push && ((count != 2'(FIFO_DEPTH)) || do_pop);
  assign dout    = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) store[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        store[wr_ptr] <= din;
        wr_ptr        <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/mem_burst_reader.sv
// Read-side initiator for the synchronous simple-dual-port memory. A start
// command reads `length` consecutive words from `base_addr` (wrapping at the
// top of the address space) and streams them out over valid/ready.
//
// Handshake: a stream word transfers on a rising edge where m_valid and
// m_ready are both high; m_valid never drops and m_data/m_last never change
// while a word is offered but not yet accepted.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, base_addr,    burst request, sampled only while idle
//   length               (length 0..2^ADDR_WIDTH)
//   busy, done           burst in progress / one-cycle completion pulse
//   read_enable, rd_add  memory read port
//   mem_data             memory data_out (1-cycle latency, holds when idle)
//   m_valid, m_data,     output stream
//   m_last, m_ready
//   state_dbg            current FSM state for observation
module mem_burst_reader
  import mem_burst_reader_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic                  read_enable,
  output logic [ADDR_WIDTH-1:0] rd_add,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic [1:0]            state_dbg
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [ADDR_WIDTH:0]   remaining;
  logic                  pending;       // a read was issued on the previous edge
  logic                  pending_last;  // ...and it was the final read of the burst
  logic                  pop;
  logic                  last_issue;
  logic [2:0]            outstanding;
  logic [DATA_WIDTH:0]   fifo_dout;
  logic [1:0]            fifo_count;
  logic                  fifo_empty;

  assign pop = m_valid && m_ready;

  // Words that will be held after this edge if nothing new is issued. Counting
  // the pop lets a read go out in the same cycle a word leaves, which keeps
  // the stream at one word per cycle while never exceeding two held words.
  assign outstanding = {1'b0, fifo_count} + {2'b00, pending} - {2'b00, pop};

  assign read_enable = (state == ST_RUN) && (remaining != '0) && (outstanding < 3'd2);
  assign last_issue  = read_enable && (remaining == (ADDR_WIDTH+1)'(1));
  assign rd_add      = addr;
  assign busy        = (state != ST_IDLE);
  assign state_dbg   = state;

  assign m_valid = !fifo_empty;
  assign m_data  = fifo_dout[DATA_WIDTH-1:0];
  assign m_last  = fifo_dout[DATA_WIDTH];

  stream_fifo2 #(
    .WIDTH (DATA_WIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (pending),
    .pop   (pop),
    .din   ({pending_last, mem_data}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      addr         <= '0;
      remaining    <= '0;
      pending      <= 1'b0;
      pending_last <= 1'b0;
      done         <= 1'b0;
    end else begin
      done         <= 1'b0;
      pending      <= read_enable;
      pending_last <= last_issue;

      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              addr      <= base_addr;
              remaining <= length;
              state     <= ST_RUN;
            end else begin
              done <= 1'b1;
            end
          end
        end

        ST_RUN: begin
          if (read_enable) begin
            addr      <= addr + ADDR_WIDTH'(1);
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
          end
          if (last_issue) state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          // The tagged last word is the final one in flight, so its
          // acceptance means the pipeline is empty after this edge.
          if (pop && m_last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_burst_reader.sv
module tb_mem_burst_reader;

  localparam int DW = 8;
  localparam int AW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic          busy, done, read_enable, m_valid, m_last;
  logic [AW-1:0] rd_add;
  logic [DW-1:0] m_data;
  logic [DW-1:0] mem_q = '0;
  logic          m_ready = 1'b0;
  logic [1:0]    state_dbg;

  mem_burst_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .busy        (busy),
    .done        (done),
    .read_enable (read_enable),
    .rd_add      (rd_add),
    .mem_data    (mem_q),
    .m_valid     (m_valid),
    .m_data      (m_data),
    .m_last      (m_last),
    .m_ready     (m_ready),
    .state_dbg   (state_dbg)
  );

  // Memory model: registered read, output holds while read_enable is low.
  logic [DW-1:0] mem_arr [256];
  always @(posedge clk) if (read_enable) mem_q <= mem_arr[rd_add];

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];       // {last, data} expected in order
  logic [AW-1:0] exp_addr_q[$];  // expected read addresses
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int words_rx = 0, issued = 0, accepted = 0, done_cnt = 0;
  int first_hs_cyc = 0, last_hs_cyc = 0, done_cyc = 0;
  logic [DW-1:0] first_data = '0;
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Monitor sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (stall_prev) begin
        chk("stall_valid", {31'd0, m_valid}, 32'd1);
        chk("stall_data", {24'd0, m_data}, {24'd0, prev_data});
        chk("stall_last", {31'd0, m_last}, {31'd0, prev_last});
      end
      if (read_enable) begin
        chk("addr_expected", exp_addr_q.size() != 0, 32'd1);
        if (exp_addr_q.size() != 0) chk("rd_add", {24'd0, rd_add}, {24'd0, exp_addr_q.pop_front()});
        chk("outstanding_le2",
            (issued - accepted + 1 - ((m_valid && m_ready) ? 1 : 0)) <= 2, 32'd1);
        issued++;
      end
      if (m_valid && m_ready) begin
        chk("word_expected", exp_q.size() != 0, 32'd1);
        if (exp_q.size() != 0) chk("word", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
        accepted++;
        words_rx++;
        if (words_rx == 1) begin
          first_hs_cyc = cyc;
          first_data   = m_data;
        end
        last_hs_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // ---------------- driver ----------------
  // mode 0: ready always high; 1: ready random 50%; 2: ready low for 5
  // cycles mid-burst; 3: ready high, extra start pulsed while busy.
  task automatic do_burst(input logic [AW-1:0] base, input logic [AW:0] len,
                          input int mode, output int launch);
    logic [AW-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = base + AW'(i);
      exp_q.push_back({(i == int'(len) - 1), mem_arr[a]});
      exp_addr_q.push_back(a);
    end
    words_rx = 0; issued = 0; accepted = 0; done_cnt = 0;
    base_addr = base;
    length    = len;
    start     = 1'b1;
    m_ready   = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    launch = cyc + 1;
    chk("re_after_start", {31'd0, read_enable}, 32'd1);
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int t = 0; t < 3000 && done_cnt == 0; t++) begin
      if (mode == 2 && t == 9) chk("stall_re_low", {31'd0, read_enable}, 32'd0);
      case (mode)
        1: m_ready = 1'($urandom_range(0, 1));
        2: m_ready = !(t >= 4 && t < 9);
        3: begin
          m_ready   = 1'b1;
          start     = (t == 2);
          base_addr = 8'h99;
          length    = 9'd3;
        end
        default: m_ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    start   = 1'b0;
    m_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("done_count", done_cnt, 32'd1);
    chk("words_left", exp_q.size(), 32'd0);
    chk("words_rx", words_rx, {23'd0, len});
    chk("done_latency", done_cyc - last_hs_cyc, 32'd1);
    chk("busy_after", {31'd0, busy}, 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  int launch;

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = 8'(i) ^ 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_rd_add", {24'd0, rd_add}, 32'd0);
    chk("rst_read_enable", {31'd0, read_enable}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic burst with constant expectations for the first word and timing.
    do_burst(8'h10, 9'd4, 0, launch);
    chk("t1_first_data", {24'd0, first_data}, 32'h4A);
    chk("t1_first_latency", first_hs_cyc - launch, 32'd2);
    chk("t1_back_to_back", last_hs_cyc - first_hs_cyc, 32'd3);

    // Address wrap at the top of memory.
    do_burst(8'hFE, 9'd4, 0, launch);

    // Backpressure mid-burst.
    do_burst(8'h00, 9'd8, 2, launch);

    // Zero-length request.
    done_cnt = 0; words_rx = 0;
    base_addr = 8'h20; length = 9'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("len0_done", {31'd0, done}, 32'd1);
    chk("len0_busy", {31'd0, busy}, 32'd0);
    chk("len0_re", {31'd0, read_enable}, 32'd0);
    @(posedge clk); #1;
    chk("len0_done_drop", {31'd0, done}, 32'd0);
    chk("len0_valid", {31'd0, m_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("len0_done_cnt", done_cnt, 32'd1);
    chk("len0_words", words_rx, 32'd0);

    // Start while busy is ignored.
    do_burst(8'h40, 9'd6, 3, launch);

    // Full address space, random backpressure.
    do_burst(8'h80, 9'h100, 1, launch);

    // Reset in the middle of a burst.
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back({(i == 9), mem_arr[8'h20 + 8'(i)]});
      exp_addr_q.push_back(8'h20 + 8'(i));
    end
    words_rx = 0; issued = 0; accepted = 0; done_cnt = 0;
    base_addr = 8'h20; length = 9'd10; start = 1'b1; m_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 0; t < 50 && words_rx < 3; t++) begin
      @(posedge clk); #1;
    end
    chk("rst_mid_reached3", words_rx, 32'd3);
    rst = 1'b1;
    m_ready = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy}, 32'd0);
    chk("rst_mid_re", {31'd0, read_enable}, 32'd0);
    chk("rst_mid_data", {24'd0, m_data}, 32'd0);
    m_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_done", done_cnt, 32'd0);
    chk("rst_mid_no_words", words_rx, 32'd3);

    // Fresh burst after reset.
    do_burst(8'h33, 9'd5, 0, launch);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_burst_reader.md
Name: mem_burst_reader

Overview:
- Read-side initiator for the team's synchronous simple-dual-port memory. It drives the memory's read_enable/rd_add port and accepts its registered data_out, which has 1-cycle read latency and holds its value when read_enable is low.
- On a start command it reads a burst of consecutive words and streams them out over a valid/ready interface with backpressure.
- It sits between the memory and a downstream consumer, such as a UART transmit path or a display streamer.

Parameters:
- DATA_WIDTH, 8, word width; must match the memory's DATA_WIDTH.
- ADDR_WIDTH, 8, address width; must match the memory's ADDR_WIDTH.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- start  in  1  burst request; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first read address; sampled with start.
- length  in  ADDR_WIDTH+1  word count, 0..2^ADDR_WIDTH; sampled with start.
- busy  out  1  high while a burst is in progress.
- done  out  1  single-cycle completion pulse.
- read_enable  out  1  to memory read_enable.
- rd_add  out  ADDR_WIDTH  to memory rd_add.
- mem_data  in  DATA_WIDTH  from memory data_out.
- m_valid  out  1  stream word valid.
- m_data  out  DATA_WIDTH  stream word.
- m_last  out  1  marks the final word of the burst.
- m_ready  in  1  consumer accepts the word when m_valid and m_ready are both high.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state goes to IDLE; FIFO, pending flag and counters are cleared.
  - busy=0, done=0, m_valid=0, m_last=0, m_data=0, rd_add=0, read_enable=0.
  - This applies mid-burst too: the burst is abandoned, no done pulse is produced, and no stale word is emitted afterwards.
- FSM states:
  - IDLE:
    - start=1 with length>0: latch addr=base_addr and remaining=length, then go to RUN.
    - start=1 with length=0: pulse done in the next cycle and stay in IDLE; no read is issued.
  - RUN: issues reads; when the read that takes remaining to 0 is issued, go to DRAIN.
  - DRAIN: wait until pending=0, the FIFO is empty, and the last word has been handshaked; then go to IDLE and set done=1 for exactly one cycle.
  - busy = (state != IDLE).
  - start while busy is ignored.
- Read issue (read_enable is combinational):
  - read_enable = RUN & remaining>0 & (fifo_count + pending - pop) < 2, where pop = m_valid & m_ready.
  - rd_add = addr register. On each issue: addr increments modulo 2^ADDR_WIDTH (wraps 0xFF -> 0x00 at default width) and remaining decrements.
  - read_enable depends combinationally on m_ready; this is intentional and gives full throughput.
- Latency capture:
  - pending is set on the edge where a read is issued.
  - On the following edge, mem_data is pushed into the 2-entry FIFO and pending clears unless a new read was issued.
  - Each FIFO entry carries {last, data}. last=1 for the word whose issue took remaining to 0.
- Output timing:
  - m_valid/m_data/m_last come from the FIFO head, registered.
  - m_data and m_last stay stable while m_valid=1 and m_ready=0.
  - With start sampled at edge 0 and m_ready held at 1: read_enable=1 after edge 0, m_valid=1 after edge 2, then 1 word/cycle.
  - done=1 in the cycle after the edge that accepts the last word.
- Invariants:
  - At most 2 words are outstanding (pending + FIFO).
  - The FIFO never overflows.
  - Words are emitted in address order.
  - Exactly `length` words are emitted per burst.

Decomposition:
- Shared include header holds:
  - state encodings (ST_IDLE, ST_RUN, ST_DRAIN);
  - FIFO_DEPTH=2.
- Sub-module stream_fifo2:
  - 2-entry synchronous FIFO, width DATA_WIDTH+1;
  - ports: push, pop, din, dout, count, empty;
  - synchronous active-high reset.

Test Plan:
- Memory preloaded mem[a]=a^0x5A, base=0x10, length=4, m_ready=1 -> data 0x4A,0x4B,0x48,0x49 on 4 consecutive cycles starting 3 edges after start; m_last only on 0x49; done pulses once, one cycle later.
- base=0xFE, length=4 -> rd_add sequence 0xFE,0xFF,0x00,0x01; data mem[0xFE],mem[0xFF],mem[0x00],mem[0x01].
- base=0x00, length=8, m_ready low for 5 cycles mid-burst -> read_enable drops once 2 words are held; m_data stable while stalled; all 8 words in order with no duplicate or loss.
- start with length=0 -> done=1 in the next cycle; read_enable and m_valid never assert; busy stays 0. Separately, start pulsed again while busy -> ignored, exactly the original length emitted.
- length=0x100, base=0x80, m_ready random 50% -> 256 words covering every address once in wrapped order; m_last on word 256 only.
- rst asserted after 3 words of a 10-word burst -> next cycle m_valid=0, busy=0, read_enable=0, no done; a new burst after reset runs correctly.
